mem_arbiter: RTL and testbench

- Memory arbiter sitting directly upstream of the single-port variable-latency RAM.
- Merges the instruction-fetch port (read-only) and the data port (read/write) onto one RAM request interface.
- Holds a registered grant until the RAM reports ACCESS, so the RAM's latency counter is never disturbed mid-transaction.
- Data has priority, with a starvation guard for instruction fetch; RAM ERROR is latched to a sticky flag.

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding CPU/RAM.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the single-port variable-latency RAM.
// Grant is held until ACCESS; data has priority with a fetch starvation guard.
//
//   state  | meaning
//   IDLE   | no grant; arbitration cycle, RAM enables low
//   IGRANT | instruction fetch owns the RAM until ACCESS or iREN drops
//   DGRANT | data port owns the RAM until ACCESS or dREN/dWEN drop
module mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.slave  arb
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] SMAX       = 4'(STARVE_MAX);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [3:0]  dcnt_next;
  logic        memerr_q;
  logic        dreq;
  logic        access;

  assign dreq   = arb.dREN | arb.dWEN;
  assign access = (arb.ramstate == RAM_ACCESS);

  // count a data completion only while a fetch is actually waiting
  assign dcnt_next = !arb.iREN ? 4'd0 :
                     (starve_cnt >= SMAX) ? SMAX : starve_cnt + 4'd1;

  function automatic state_t arbitrate(input logic ireq, input logic dr,
                                       input logic [3:0] cnt);
    if (dr && !(ireq && cnt == SMAX)) return DGRANT;
    else if (ireq)                    return IGRANT;
    else                              return IDLE;
  endfunction

  // ACCESS is honoured before an abort so a request dropped in its own
  // completion cycle still completes and the next grant follows without a gap
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      memerr_q   <= 1'b0;
    end else begin
      if (arb.ramstate == RAM_ERROR && state != IDLE) memerr_q <= 1'b1;
      case (state)
        IDLE: begin
          state <= arbitrate(arb.iREN, dreq, starve_cnt);
          if (!arb.iREN) starve_cnt <= 4'd0;
        end
        IGRANT: begin
          if (access) begin
            starve_cnt <= 4'd0;
            state      <= arbitrate(arb.iREN, dreq, 4'd0);
          end else if (!arb.iREN) begin
            state <= IDLE;
          end
        end
        DGRANT: begin
          if (access) begin
            starve_cnt <= dcnt_next;
            state      <= arbitrate(arb.iREN, dreq, dcnt_next);
          end else if (!dreq) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    arb.ramREN   = 1'b0;
    arb.ramWEN   = 1'b0;
    arb.ramaddr  = 32'd0;
    arb.ramstore = 32'd0;
    case (state)
      IGRANT: begin
        arb.ramREN  = 1'b1;
        arb.ramaddr = arb.iaddr;
      end
      DGRANT: begin
        arb.ramREN   = ~arb.dWEN;
        arb.ramWEN   = arb.dWEN;
        arb.ramaddr  = arb.daddr;
        arb.ramstore = arb.dstore;
      end
      default: ;
    endcase
  end

  assign arb.iwait  = arb.iREN & ~(state == IGRANT && access);
  assign arb.dwait  = dreq & ~(state == DGRANT && access);
  assign arb.iload  = arb.ramload;
  assign arb.dload  = arb.ramload;
  assign arb.memerr = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural variable-latency RAM, a vector table of
// single transactions, and directed sequences for the multi-cycle corner cases.
module tb_mem_arbiter;

  logic CLK;
  logic nRST;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .arb  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model: ACCESS on the lat-th consecutive cycle of a stable request;
  // unwritten words read as A5A5_<low 16 address bits>
  int          lat = 2;
  logic        force_err = 1'b0;
  logic        rvalid;
  logic [31:0] raddr_q;
  int          rcnt;
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  int          wn = 0;
  logic        ram_en;
  logic        ram_hit;

  always_comb begin
    ram_en  = bus.ramREN | bus.ramWEN;
    ram_hit = rvalid && (raddr_q == bus.ramaddr);
    if (force_err)                          bus.ramstate = 2'd3;
    else if (!ram_en)                       bus.ramstate = 2'd0;
    else if ((ram_hit ? rcnt : 0) == lat-1) bus.ramstate = 2'd2;
    else                                    bus.ramstate = 2'd1;
    bus.ramload = 32'hA5A5_0000 | {16'h0, bus.ramaddr[15:0]};
    for (int i = 0; i < 8; i++)
      if (i < wn && wa[i] == bus.ramaddr) bus.ramload = wd[i];
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rvalid  <= 1'b0;
      rcnt    <= 0;
      raddr_q <= 32'd0;
    end else begin
      if (!ram_en || bus.ramstate == 2'd2) begin
        rvalid <= 1'b0;
        rcnt   <= 0;
      end else if (ram_hit) begin
        rcnt <= rcnt + 1;
      end else begin
        rvalid  <= 1'b1;
        raddr_q <= bus.ramaddr;
        rcnt    <= 1;
      end
      if (bus.ramWEN && bus.ramstate == 2'd2 && wn < 8) begin
        wa[wn] <= bus.ramaddr;
        wd[wn] <= bus.ramstore;
        wn     <= wn + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // kind: 0 = fetch, 1 = data read, 2 = data write (dREN and dWEN both high)
  task automatic run_txn(input logic [1:0] kind, input logic [31:0] addr,
                         input logic [31:0] wdata, input int l, input bit rel,
                         output int k, output int first_en, output logic [31:0] ld,
                         output logic ren, output logic wen, output logic [31:0] ra);
    @(posedge CLK); #1;
    lat = l;
    if (rel) nRST = 1'b1;
    case (kind)
      2'd0: begin bus.iREN = 1'b1; bus.iaddr = addr; end
      2'd1: begin bus.dREN = 1'b1; bus.daddr = addr; end
      default: begin
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = addr; bus.dstore = wdata;
      end
    endcase
    k = 0; first_en = 0; ld = 32'd0; ren = 1'b0; wen = 1'b0; ra = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (first_en == 0 && (bus.ramREN || bus.ramWEN)) first_en = c;
      if ((kind == 2'd0 && !bus.iwait) || (kind != 2'd0 && !bus.dwait)) begin
        k   = c;
        ld  = (kind == 2'd0) ? bus.iload : bus.dload;
        ren = bus.ramREN;
        wen = bus.ramWEN;
        ra  = bus.ramaddr;
        break;
      end
    end
    // a write must stay a write through the commit edge
    if (kind == 2'd2) begin @(posedge CLK); #1; end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_k;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_ld;
    bit          chk_ld;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, fe, n, c;
    bit seen;
    logic [31:0] ld, ra;
    logic ren, wen;

    vecs[0] = '{2'd2, 32'h200,  32'hDEADBEEF, 3, 4, 1'b0, 1'b1, 32'h0,        1'b0};
    vecs[1] = '{2'd1, 32'h200,  32'h0,        2, 3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{2'd0, 32'h1000, 32'h0,        2, 3, 1'b1, 1'b0, 32'hA5A51000, 1'b1};
    vecs[3] = '{2'd1, 32'h104,  32'h0,        4, 5, 1'b1, 1'b0, 32'hA5A50104, 1'b1};
    vecs[4] = '{2'd2, 32'h300,  32'h12345678, 1, 2, 1'b0, 1'b1, 32'h0,        1'b0};
    vecs[5] = '{2'd0, 32'h300,  32'h0,        3, 4, 1'b1, 1'b0, 32'h12345678, 1'b1};
    vecs[6] = '{2'd1, 32'h40,   32'h0,        1, 2, 1'b1, 1'b0, 32'hA5A50040, 1'b1};

    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;

    // reset values, then release straight into a fetch of 0x40, latency 5
    repeat (3) @(negedge CLK);
    chk("rst_ramREN",   32'(bus.ramREN),  32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN),  32'd0);
    chk("rst_ramaddr",  bus.ramaddr,      32'd0);
    chk("rst_ramstore", bus.ramstore,     32'd0);
    chk("rst_iwait",    32'(bus.iwait),   32'd0);
    chk("rst_dwait",    32'(bus.dwait),   32'd0);
    chk("rst_memerr",   32'(bus.memerr),  32'd0);
    run_txn(2'd0, 32'h40, 32'h0, 5, 1'b1, k, fe, ld, ren, wen, ra);
    chk("rel_first_ren", 32'(fe), 32'd2);
    chk("rel_cycles",    32'(k),  32'd6);
    chk("rel_iload",     ld,      32'hA5A50040);

    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].kind, vecs[v].addr, vecs[v].wdata, vecs[v].lat, 1'b0,
              k, fe, ld, ren, wen, ra);
      chk($sformatf("vec%0d_cycles", v), 32'(k),   32'(vecs[v].exp_k));
      chk($sformatf("vec%0d_ramREN", v), 32'(ren), 32'(vecs[v].exp_ren));
      chk($sformatf("vec%0d_ramWEN", v), 32'(wen), 32'(vecs[v].exp_wen));
      chk($sformatf("vec%0d_ramaddr", v), ra,      vecs[v].addr);
      if (vecs[v].chk_ld) chk($sformatf("vec%0d_load", v), ld, vecs[v].exp_ld);
    end

    // simultaneous fetch and data read: data first, fetch with no IDLE gap
    @(posedge CLK); #1;
    lat = 3; bus.iaddr = 32'h80; bus.daddr = 32'h100; bus.iREN = 1'b1; bus.dREN = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (!bus.dwait) begin k = i; break; end
    end
    chk("both_d_cycles", 32'(k), 32'd4);
    chk("both_iwait_hi", 32'(bus.iwait), 32'd1);
    chk("both_dload",    bus.dload, 32'hA5A50100);
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("both_nogap_ren",  32'(bus.ramREN), 32'd1);
    chk("both_nogap_addr", bus.ramaddr, 32'h80);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      if (!bus.iwait) begin k = i; break; end
      @(negedge CLK);
    end
    chk("both_i_cycles", 32'(k), 32'd3);
    chk("both_iload",    bus.iload, 32'hA5A50080);
    bus.iREN = 1'b0;
    repeat (2) @(negedge CLK);

    // starvation guard: two rounds of three data completions, each then a fetch
    @(posedge CLK); #1;
    lat = 2; bus.iaddr = 32'h500; bus.daddr = 32'h800; bus.iREN = 1'b1; bus.dREN = 1'b1;
    for (int r = 0; r < 2; r++) begin
      n = 0; seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge CLK);
        if (bus.ramREN && bus.ramaddr == 32'h500) begin seen = 1'b1; break; end
        if (!bus.dwait) begin
          n++;
          @(posedge CLK); #1;
          bus.daddr = bus.daddr + 32'd4;
        end
      end
      chk($sformatf("starve_r%0d_igrant", r), 32'(seen), 32'd1);
      chk($sformatf("starve_r%0d_dcount", r), 32'(n), 32'd3);
      if (r == 0) begin
        c = 0;
        for (int i = 1; i <= 40; i++) begin
          if (!bus.iwait) begin c = i; break; end
          @(negedge CLK);
        end
        chk("starve_i_cycles", 32'(c), 32'd2);
        chk("starve_iload",    bus.iload, 32'hA5A50500);
      end
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    repeat (2) @(negedge CLK);

    // data read aborted two cycles into its grant
    @(posedge CLK); #1;
    lat = 5; bus.daddr = 32'h600; bus.dREN = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (!bus.dwait) n++;
    end
    chk("abort_dwait_low_cnt", 32'(n), 32'd0);
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("abort_ramREN",  32'(bus.ramREN), 32'd0);
    chk("abort_ramaddr", bus.ramaddr, 32'd0);
    chk("abort_dwait",   32'(bus.dwait), 32'd0);
    repeat (2) @(negedge CLK);

    // one ERROR cycle during a fetch grant sets the sticky flag
    @(posedge CLK); #1;
    lat = 4; bus.iaddr = 32'h700; bus.iREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("err_before", 32'(bus.memerr), 32'd0);
    force_err = 1'b1;
    @(negedge CLK);
    force_err = 1'b0;
    chk("err_set", 32'(bus.memerr), 32'd1);
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      if (!bus.iwait) begin c = i; break; end
      @(negedge CLK);
    end
    chk("err_i_cycles", 32'(c), 32'd3);
    chk("err_iload",    bus.iload, 32'hA5A50700);
    bus.iREN = 1'b0;
    repeat (2) @(negedge CLK);
    run_txn(2'd1, 32'h104, 32'h0, 2, 1'b0, k, fe, ld, ren, wen, ra);
    chk("err_sticky_load", ld, 32'hA5A50104);
    chk("err_sticky",      32'(bus.memerr), 32'd1);

    // reset pulse in the middle of a data grant
    @(posedge CLK); #1;
    lat = 5; bus.daddr = 32'h900; bus.dREN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("midrst_granted", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("midrst_memerr", 32'(bus.memerr), 32'd0);
    chk("midrst_ramREN", 32'(bus.ramREN), 32'd0);
    bus.dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("post_rst_memerr", 32'(bus.memerr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
